xgmii_rx_checker: RTL

XGMII_RX_CHECKER -- requirements
Module: xgmii_rx_checker

---
 rtl/xgmii_rx_checker_if.sv | 20 ++
 rtl/xgmii_rx_checker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_checker_if.sv
// xgmii_rx_checker_if: XGMII receive bus, counter clear and frame-result signals of the checker
interface xgmii_rx_checker_if;
  logic [63:0] xgmii_rxd;
  logic [7:0] xgmii_rxc;
  logic clear;
  logic [31:0] good_count;
  logic [31:0] crc_err_count;
  logic [31:0] frm_err_count;
  logic [15:0] last_len;
  logic done;
  logic done_good;
  modport master (
    output xgmii_rxd, xgmii_rxc, clear,
    input good_count, crc_err_count, frm_err_count, last_len, done, done_good
  );
  modport slave (
    input xgmii_rxd, xgmii_rxc, clear,
    output good_count, crc_err_count, frm_err_count, last_len, done, done_good
  );
endinterface

// File: rtl/xgmii_rx_checker.sv
// xgmii_rx_checker: checks XGMII receive frames for framing, length and FCS, counting each outcome
module xgmii_rx_checker #(
  parameter logic [15:0] MaxLen = 16'd1518,
  parameter logic [15:0] MinLen = 16'd64
) (
  input logic xgemac_clk_156,
  input logic sys_rst,
  xgmii_rx_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, len_n, len_s1, last_len_q;
  logic [16:0] cnt_8;
  logic [31:0] crc, crc_n, crc_all, crc_k, crc_s1, good_q, crc_err_q, frm_err_q;
  logic [7:0] lo_mask;
  logic [2:0] k;
  logic has_fd, is_start, sfd_ok, lane4_start, is_term, hi_ok;
  logic v_n, term_n, err_n, v_s1, term_s1, err_s1;
  logic in_range, good, crc_e, frm_e, done_q, done_good_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  always_comb begin
    k = 3'd0;
    has_fd = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      k = bus.xgmii_rxc[i] ? 3'(i) : k;
      has_fd = has_fd | (bus.xgmii_rxc[i] && bus.xgmii_rxd[8*i +: 8] == 8'hFD);
    end
  end

  always_comb begin
    crc_all = crc;
    crc_k = crc;
    for (int i = 0; i < 8; i++) begin
      crc_k = (3'(i) == k) ? crc_all : crc_k;
      crc_all = crc_byte(crc_all, bus.xgmii_rxd[8*i +: 8]);
    end
  end

  assign lo_mask = (8'd1 << k) - 8'd1;
  assign hi_ok = &(bus.xgmii_rxc | lo_mask);
  assign is_term = bus.xgmii_rxd[{k, 3'b000} +: 8] == 8'hFD;
  assign is_start = bus.xgmii_rxc == 8'h01 && bus.xgmii_rxd[55:0] == 56'h555555555555FB;
  assign sfd_ok = bus.xgmii_rxd[63:56] == 8'hD5;
  assign lane4_start = bus.xgmii_rxc == 8'h10 && bus.xgmii_rxd[39:32] == 8'hFB;
  assign cnt_8 = {1'b0, cnt} + 17'd8;
  assign len_n = cnt + 16'(k);

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    crc_n = crc;
    v_n = 1'b0;
    term_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        if (is_start) begin
          v_n = !sfd_ok;
          err_n = !sfd_ok;
          state_n = sfd_ok ? DATA : DROP;
          cnt_n = 16'd0;
          crc_n = 32'hFFFFFFFF;
        end else if (lane4_start) begin
          v_n = 1'b1;
          err_n = 1'b1;
        end
      end
      DATA: begin
        if (bus.xgmii_rxc == 8'h00) begin
          v_n = cnt_8 > {1'b0, MaxLen};
          err_n = v_n;
          state_n = v_n ? DROP : DATA;
          cnt_n = v_n ? cnt : cnt_8[15:0];
          crc_n = v_n ? crc : crc_all;
        end else if (is_start && sfd_ok) begin
          v_n = 1'b1;
          err_n = 1'b1;
          cnt_n = 16'd0;
          crc_n = 32'hFFFFFFFF;
        end else begin
          v_n = 1'b1;
          term_n = is_term;
          err_n = !is_term || !hi_ok;
          state_n = is_term ? IDLE : DROP;
        end
      end
      DROP: state_n = (has_fd || bus.xgmii_rxc == 8'hFF) ? IDLE : DROP;
      default: state_n = IDLE;
    endcase
  end

  assign in_range = len_s1 >= MinLen && len_s1 <= MaxLen;
  assign good = v_s1 && term_s1 && !err_s1 && in_range && crc_s1 == 32'hDEBB20E3;
  assign crc_e = v_s1 && term_s1 && !err_s1 && in_range && crc_s1 != 32'hDEBB20E3;
  assign frm_e = v_s1 && (err_s1 || (term_s1 && !in_range));

  always_ff @(posedge xgemac_clk_156) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt <= 16'd0;
      crc <= 32'hFFFFFFFF;
      v_s1 <= 1'b0;
      term_s1 <= 1'b0;
      err_s1 <= 1'b0;
      len_s1 <= 16'd0;
      crc_s1 <= 32'hFFFFFFFF;
      good_q <= 32'd0;
      crc_err_q <= 32'd0;
      frm_err_q <= 32'd0;
      last_len_q <= 16'd0;
      done_q <= 1'b0;
      done_good_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      crc <= crc_n;
      v_s1 <= v_n;
      term_s1 <= term_n;
      err_s1 <= err_n;
      len_s1 <= len_n;
      crc_s1 <= crc_k;
      good_q <= bus.clear ? 32'd0 : (good && !(&good_q)) ? good_q + 32'd1 : good_q;
      crc_err_q <= bus.clear ? 32'd0 : (crc_e && !(&crc_err_q)) ? crc_err_q + 32'd1 : crc_err_q;
      frm_err_q <= bus.clear ? 32'd0 : (frm_e && !(&frm_err_q)) ? frm_err_q + 32'd1 : frm_err_q;
      last_len_q <= (v_s1 && term_s1) ? len_s1 : last_len_q;
      done_q <= v_s1;
      done_good_q <= good;
    end
  end

  assign bus.good_count = good_q;
  assign bus.crc_err_count = crc_err_q;
  assign bus.frm_err_count = frm_err_q;
  assign bus.last_len = last_len_q;
  assign bus.done = done_q;
  assign bus.done_good = done_good_q;
endmodule
